// File: rtl/dff_reg.sv
// Parameterised DEPTH-stage register pipeline with synchronous reset to RESET_VALUE.
// Define DFF_REG_CHECK_EN to compile a simulation-only shadow model that checks Q.
module dff_reg #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // The initialiser makes every stage start at RESET_VALUE, so Q is never X before the first edge.
    logic [WIDTH-1:0] stage_q [DEPTH] = '{default: RESET_VALUE};
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = D;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign Q = stage_q[DEPTH-1];

`ifdef DFF_REG_CHECK_EN
    // Each edge compares Q with the shadow before either one updates, i.e. the state left by the previous edge.
    logic [WIDTH-1:0] shadow_q [DEPTH] = '{default: RESET_VALUE};

    always @(posedge clk) begin
        if (Q !== shadow_q[DEPTH-1]) begin
            $error("dff_reg check at %0t: expected %h, actual %h", $time, shadow_q[DEPTH-1], Q);
        end
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                shadow_q[k] <= RESET_VALUE;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                shadow_q[k] <= shadow_q[k-1];
            end
            shadow_q[0] <= D;
        end
    end
`endif

endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg: a default 1x1 instance and an 8-bit, 3-deep instance with reset value A5,
// both checked against an edge-history reference model.
`timescale 1ns/1ps
module tb_dff_reg;

   localparam int MAXEDGES = 1024;

   logic       clk;
   logic       rst1, rst3;
   logic       d1, q1;
   logic [7:0] d3, q3;

   int passCount = 0;
   int checkCount = 0;
   int edgeCount = 0;

   logic [7:0] dHist1 [MAXEDGES];
   logic       rHist1 [MAXEDGES];
   logic [7:0] dHist3 [MAXEDGES];
   logic       rHist3 [MAXEDGES];

   dff_reg dut1 (
      .clk   (clk),
      .reset (rst1),
      .D     (d1),
      .Q     (q1)
   );

   dff_reg #(
      .WIDTH       (8),
      .DEPTH       (3),
      .RESET_VALUE (8'hA5)
   ) dut3 (
      .clk   (clk),
      .reset (rst3),
      .D     (d3),
      .Q     (q3)
   );

   // 40 ns period, first rising edge at 20 ns.
   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Record what each instance sees on every rising edge; the model works from this history only.
   always @(posedge clk) begin
      if (edgeCount < MAXEDGES) begin
         dHist1[edgeCount] = {7'b0, d1};
         rHist1[edgeCount] = rst1;
         dHist3[edgeCount] = d3;
         rHist3[edgeCount] = rst3;
      end
      edgeCount = edgeCount + 1;
   end

   // Q after edge e is the D sampled DEPTH-1 edges earlier, unless a reset edge happened at or after
   // that sample, or that sample predates the first edge; in both cases it is the reset value.
   function automatic logic [63:0] expectedQ(input int inst, input int e);
      int depth;
      logic [63:0] rv;
      int first;
      depth = (inst == 1) ? 1 : 3;
      rv    = (inst == 1) ? 64'h0 : 64'hA5;
      first = e - depth + 1;
      if (e < 0 || first < 0) return rv;
      for (int k = first; k <= e; k++) begin
         if ((inst == 1) ? rHist1[k] : rHist3[k]) return rv;
      end
      return (inst == 1) ? {56'b0, dHist1[first]} : {56'b0, dHist3[first]};
   endfunction

   // Compares observed against expected, counting every comparison.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
      end else begin
         passCount = passCount + 1;
      end
   endtask

   // Checks both instances against the model for the latest edge.
   task automatic checkBoth(input string tag);
      checkOutput({tag, "_q1"}, {63'b0, q1}, expectedQ(1, edgeCount - 1));
      checkOutput({tag, "_q3"}, {56'b0, q3}, expectedQ(3, edgeCount - 1));
   endtask

   // Called just after a falling edge: drives inputs, optionally glitches D and reset mid-cycle
   // (Q must not move), then checks both outputs at the next falling edge.
   task automatic applyStimulus(input string tag, input logic dv1, input logic rv1,
                                input logic [7:0] dv3, input logic rv3, input bit glitch);
      logic q1Before;
      logic [7:0] q3Before;
      d1 = dv1; rst1 = rv1; d3 = dv3; rst3 = rv3;
      if (glitch) begin
         q1Before = q1;
         q3Before = q3;
         #4;
         d1 = ~dv1; rst1 = ~rv1; d3 = ~dv3; rst3 = ~rv3;
         #4;
         checkOutput({tag, "_hold_q1"}, {63'b0, q1}, {63'b0, q1Before});
         checkOutput({tag, "_hold_q3"}, {56'b0, q3}, {56'b0, q3Before});
         d1 = dv1; rst1 = rv1; d3 = dv3; rst3 = rv3;
      end
      @(negedge clk);
      checkBoth(tag);
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; d1 = 1'b0; d3 = 8'h00;
      #1;
      checkOutput("time0_q1", {63'b0, q1}, 64'h0);
      checkOutput("time0_q3", {56'b0, q3}, 64'hA5);
      #9;
      rst1 = 1'b0;
      #9;
      checkOutput("preEdge_q1", {63'b0, q1}, 64'h0);
      @(negedge clk);
      checkBoth("firstEdge");
      checkOutput("firstEdge_const_q3", {56'b0, q3}, 64'hA5);

      // Default instance directed: 1 at the 60 ns edge, 0 at 100 ns, then a mid-cycle glitch.
      // Wide instance directed: 01, 02, 03 on consecutive edges after its reset edge.
      applyStimulus("d1High", 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      checkOutput("d1High_const", {63'b0, q1}, 64'h1);
      checkOutput("lat1_const", {56'b0, q3}, 64'hA5);
      applyStimulus("d1Low", 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
      checkOutput("d1Low_const", {63'b0, q1}, 64'h0);
      checkOutput("lat2_const", {56'b0, q3}, 64'hA5);
      applyStimulus("toggle", 1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
      checkOutput("out01_const", {56'b0, q3}, 64'h01);
      applyStimulus("resetD1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("resetD1_const", {63'b0, q1}, 64'h0);
      checkOutput("out02_const", {56'b0, q3}, 64'h02);
      applyStimulus("seq3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("out03_const", {56'b0, q3}, 64'h03);

      // Mid-stream reset on the wide instance discards data in flight.
      applyStimulus("fill1", 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
      applyStimulus("fill2", 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
      applyStimulus("fill3", 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
      applyStimulus("midReset", 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
      checkOutput("midReset_const", {56'b0, q3}, 64'hA5);
      applyStimulus("post1", 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      checkOutput("post1_const", {56'b0, q3}, 64'hA5);
      applyStimulus("post2", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      checkOutput("post2_const", {56'b0, q3}, 64'hA5);
      applyStimulus("post3", 1'b0, 1'b0, 8'h12, 1'b0, 1'b0);
      checkOutput("post3_const", {56'b0, q3}, 64'h10);

      // Randomised traffic with occasional resets and mid-cycle glitches.
      for (int i = 0; i < 300; i++) begin
         applyStimulus("rand",
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0),
                       8'($urandom_range(0, 255)),
                       ($urandom_range(0, 11) == 0),
                       ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
